// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: default datapath widths and
// the ALU operation encoding that the control state machine drives onto
// ALU_s0.
package proc_pkg;

  localparam int DEF_DATA_W = 16;  // datapath word width
  localparam int DEF_RF_AW  = 4;   // register-file address width (16 regs)
  localparam int DEF_DM_AW  = 8;   // data-memory address width (256 words)
  localparam int ALU_SEL_W  = 3;   // ALU select width

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ZERO = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NOT  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_t;

endpackage

// File: rtl/reg_file.sv
// Register file: 2^AW words of DATA_W bits, two asynchronous read ports and
// one synchronous write port. The asynchronous reset clears every register.
//   clk, reset        rising-edge clock, async active-high clear
//   we, w_addr, w_data  write port, sampled on the rising edge
//   ra_addr/ra_data   read port A (combinational)
//   rb_addr/rb_data   read port B (combinational)
module reg_file #(
  parameter int DATA_W = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] regs [2**AW];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its inputs from before the edge; this is also what
  // makes a read of the register being written return the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else if (we) begin
      regs[w_addr] <= w_data;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the pre-edge contents.
  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/datapath_unit.sv
// Execution datapath of the 16-bit processor. Driven directly by the
// controller's per-state control word; holds the register file, the ALU,
// the data memory and the write-back mux.
//   clk, reset      rising-edge clock, async active-high clear (RF and D_q)
//   D_addr, D_wr    data-memory address and write strobe (write data = Ra_data)
//   RF_s            write-back select: 1 = memory read word, 0 = ALU result
//   RF_W_addr/en    register-file write port
//   RF_Ra_addr      read port A address (also the STORE source)
//   RF_Rb_addr      read port B address
//   ALU_s0          ALU operation select (proc_pkg::alu_op_t encoding)
//   Ra_data/Rb_data register-file read ports
//   ALU_out, ALU_Z  ALU result and its zero flag
//   W_data          write-back mux output
module datapath_unit
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RF_AW  = DEF_RF_AW,
  parameter int DM_AW  = DEF_DM_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DM_AW-1:0]     D_addr,
  input  logic                 D_wr,
  input  logic                 RF_s,
  input  logic [RF_AW-1:0]     RF_W_addr,
  input  logic                 RF_W_en,
  input  logic [RF_AW-1:0]     RF_Ra_addr,
  input  logic [RF_AW-1:0]     RF_Rb_addr,
  input  logic [ALU_SEL_W-1:0] ALU_s0,
  output logic [DATA_W-1:0]    Ra_data,
  output logic [DATA_W-1:0]    Rb_data,
  output logic [DATA_W-1:0]    ALU_out,
  output logic                 ALU_Z,
  output logic [DATA_W-1:0]    W_data
);

  logic [DATA_W-1:0] mem [2**DM_AW];
  logic [DATA_W-1:0] D_q;
  alu_op_t           alu_op;

  reg_file #(
    .DATA_W (DATA_W),
    .AW     (RF_AW)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .we      (RF_W_en),
    .w_addr  (RF_W_addr),
    .w_data  (W_data),
    .ra_addr (RF_Ra_addr),
    .rb_addr (RF_Rb_addr),
    .ra_data (Ra_data),
    .rb_data (Rb_data)
  );

  assign alu_op = alu_op_t'(ALU_s0);

  // NOTE: ALU_out gets a default before the case so every path assigns it;
  // otherwise an uncovered select would infer a latch.
  always_comb begin
    ALU_out = '0;
    case (alu_op)
      ALU_ZERO: ALU_out = '0;
      ALU_ADD:  ALU_out = Ra_data + Rb_data;
      ALU_SUB:  ALU_out = Ra_data - Rb_data;
      ALU_AND:  ALU_out = Ra_data & Rb_data;
      ALU_OR:   ALU_out = Ra_data | Rb_data;
      ALU_XOR:  ALU_out = Ra_data ^ Rb_data;
      ALU_NOT:  ALU_out = ~Ra_data;
      ALU_PASS: ALU_out = Ra_data;
      default:  ALU_out = '0;
    endcase
  end

  assign ALU_Z = (ALU_out == '0);

  // NOTE: the memory array has no reset so it maps onto block RAM; only the
  // read register is cleared. Writes are still suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (D_wr && !reset) mem[D_addr] <= Ra_data;
  end

  // Read-first: on a write to the same address D_q captures the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) D_q <= '0;
    else       D_q <= mem[D_addr];
  end

  assign W_data = RF_s ? D_q : ALU_out;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed self-checking bench for datapath_unit. Inputs change 1 time unit
// after each rising edge; outputs are sampled well away from the edge.
module tb_datapath_unit;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [15:0] Ra_data;
  logic [15:0] Rb_data;
  logic [15:0] ALU_out;
  logic        ALU_Z;
  logic [15:0] W_data;

  int n_tests  = 0;
  int n_failed = 0;

  always #5 clk = ~clk;

  datapath_unit dut (
    .clk        (clk),
    .reset      (reset),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .Ra_data    (Ra_data),
    .Rb_data    (Rb_data),
    .ALU_out    (ALU_out),
    .ALU_Z      (ALU_Z),
    .W_data     (W_data)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_wr    = 1'b0;
    RF_W_en = 1'b0;
    RF_s    = 1'b0;
  endtask

  // One ADD/SUB-style state: w <= op(ra, rb).
  task automatic alu_wr(input logic [3:0] w, input logic [3:0] ra,
                        input logic [3:0] rb, input alu_op_t op);
    RF_Ra_addr = ra;
    RF_Rb_addr = rb;
    RF_W_addr  = w;
    ALU_s0     = op;
    RF_s       = 1'b0;
    RF_W_en    = 1'b1;
    D_wr       = 1'b0;
    tick();
    idle();
  endtask

  task automatic store(input logic [3:0] ra, input logic [7:0] addr);
    RF_Ra_addr = ra;
    D_addr     = addr;
    D_wr       = 1'b1;
    RF_W_en    = 1'b0;
    tick();
    idle();
  endtask

  task automatic load_a(input logic [7:0] addr);
    D_addr  = addr;
    D_wr    = 1'b0;
    RF_W_en = 1'b0;
    tick();
  endtask

  task automatic load_b(input logic [3:0] w);
    RF_s      = 1'b1;
    RF_W_addr = w;
    RF_W_en   = 1'b1;
    tick();
    idle();
  endtask

  // Read a register through port B (port A is left alone).
  task automatic check_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    RF_Rb_addr = a;
    #1;
    check(tag, Rb_data, exp);
  endtask

  // Builds an arbitrary constant in register rd by shift-and-add; R8 holds 1.
  task automatic build_const(input logic [3:0] rd, input logic [15:0] value);
    alu_wr(rd, rd, rd, ALU_ZERO);
    for (int b = 15; b >= 0; b--) begin
      alu_wr(rd, rd, rd, ALU_ADD);
      if (value[b]) alu_wr(rd, rd, 4'd8, ALU_ADD);
    end
  endtask

  logic [15:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 16'h0000; sweep_exp[1] = 16'h10E0;
    sweep_exp[2] = 16'hF100; sweep_exp[3] = 16'h00F0;
    sweep_exp[4] = 16'h0FF0; sweep_exp[5] = 16'h0F00;
    sweep_exp[6] = 16'hFF0F; sweep_exp[7] = 16'h00F0;

    reset = 1'b1;
    D_addr = '0; RF_W_addr = '0; RF_Ra_addr = 4'd3; RF_Rb_addr = 4'd5;
    ALU_s0 = ALU_ADD;
    idle();

    // Reset state
    #2;
    check("rst_ra", Ra_data, 16'h0000);
    check("rst_rb", Rb_data, 16'h0000);
    check("rst_w_alu", W_data, 16'h0000);
    check("rst_z", {15'd0, ALU_Z}, 16'h0001);
    ALU_s0 = ALU_NOT;
    #1;
    check("rst_not", ALU_out, 16'hFFFF);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Derive small constants from the zeroed register file
    alu_wr(4'd9, 4'd0, 4'd0, ALU_NOT);          // R9 = FFFF
    check_reg("r9_ffff", 4'd9, 16'hFFFF);
    alu_wr(4'd8, 4'd0, 4'd9, ALU_SUB);          // R8 = 0 - FFFF = 1
    check_reg("r8_one", 4'd8, 16'h0001);
    alu_wr(4'd10, 4'd8, 4'd8, ALU_ADD);         // R10 = 2
    alu_wr(4'd11, 4'd10, 4'd10, ALU_ADD);       // R11 = 4
    alu_wr(4'd12, 4'd11, 4'd8, ALU_ADD);        // R12 = 5
    alu_wr(4'd13, 4'd10, 4'd8, ALU_ADD);        // R13 = 3

    // Preload R1/R2 through memory
    store(4'd12, 8'd1);
    store(4'd13, 8'd2);
    load_a(8'd1);
    check_reg("r1_after_load_a", 4'd1, 16'h0000);
    RF_s = 1'b1;
    #1;
    check("load_b_wdata", W_data, 16'h0005);
    load_b(4'd1);
    check_reg("r1_loaded", 4'd1, 16'h0005);
    load_a(8'd2);
    load_b(4'd2);
    check_reg("r2_loaded", 4'd2, 16'h0003);

    // ADD then SUB (wrap)
    RF_Ra_addr = 4'd1; RF_Rb_addr = 4'd2; ALU_s0 = ALU_ADD; RF_s = 1'b0;
    #1;
    check("add_comb", ALU_out, 16'h0008);
    alu_wr(4'd3, 4'd1, 4'd2, ALU_ADD);
    check_reg("add_r3", 4'd3, 16'h0008);
    alu_wr(4'd3, 4'd2, 4'd1, ALU_SUB);
    check_reg("sub_r3_wrap", 4'd3, 16'hFFFE);

    // Register read during write: old value until the edge
    alu_wr(4'd4, 4'd10, 4'd10, ALU_PASS);       // R4 = 2
    RF_Ra_addr = 4'd4; RF_Rb_addr = 4'd1; RF_W_addr = 4'd4;
    ALU_s0 = ALU_ADD; RF_s = 1'b0; RF_W_en = 1'b1;
    #1;
    check("rdw_ra_old", Ra_data, 16'h0002);
    check("rdw_alu", ALU_out, 16'h0007);
    tick();
    idle();
    check("rdw_ra_new", Ra_data, 16'h0007);

    // STORE R15=BEEF then LOAD into R7
    build_const(4'd15, 16'hBEEF);
    check_reg("r15_beef", 4'd15, 16'hBEEF);
    store(4'd15, 8'd41);
    load_a(8'd41);
    check_reg("r7_after_load_a", 4'd7, 16'h0000);
    load_b(4'd7);
    check_reg("r7_loaded", 4'd7, 16'hBEEF);

    // Memory read-first
    build_const(4'd5, 16'h1111);
    build_const(4'd6, 16'h2222);
    store(4'd5, 8'd10);
    RF_Ra_addr = 4'd6; D_addr = 8'd10; D_wr = 1'b1; RF_s = 1'b1; RF_W_en = 1'b0;
    tick();
    D_wr = 1'b0;
    check("mem_rdw_old", W_data, 16'h1111);
    tick();
    check("mem_rdw_new", W_data, 16'h2222);
    idle();

    // Register write and memory write on the same edge
    RF_Ra_addr = 4'd9; ALU_s0 = ALU_PASS; RF_s = 1'b0;
    RF_W_addr = 4'd14; RF_W_en = 1'b1; D_addr = 8'd3; D_wr = 1'b1;
    tick();
    idle();
    check_reg("dual_r14", 4'd14, 16'hFFFF);
    load_a(8'd3);
    RF_s = 1'b1;
    #1;
    check("dual_mem", W_data, 16'hFFFF);
    idle();

    // ALU sweep
    build_const(4'd5, 16'h00F0);
    build_const(4'd6, 16'h0FF0);
    RF_Ra_addr = 4'd5; RF_Rb_addr = 4'd6; RF_s = 1'b0;
    for (int op = 0; op < 8; op++) begin
      ALU_s0 = 3'(op);
      #1;
      check($sformatf("alu_op%0d", op), ALU_out, sweep_exp[op]);
      check($sformatf("alu_z%0d", op), {15'd0, ALU_Z}, (op == 0) ? 16'h0001 : 16'h0000);
      check($sformatf("alu_wdata%0d", op), W_data, sweep_exp[op]);
    end

    // Reset mid-LOAD with nonzero state
    load_a(8'd41);
    RF_Ra_addr = 4'd15; RF_Rb_addr = 4'd7; RF_s = 1'b1;
    #1;
    check("pre_rst_ra", Ra_data, 16'hBEEF);
    check("pre_rst_dq", W_data, 16'hBEEF);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_ra", Ra_data, 16'h0000);
    check("mid_rst_rb", Rb_data, 16'h0000);
    check("mid_rst_w_mem", W_data, 16'h0000);
    RF_s = 1'b0; ALU_s0 = ALU_ADD;
    #1;
    check("mid_rst_w_alu", W_data, 16'h0000);
    check("mid_rst_z", {15'd0, ALU_Z}, 16'h0001);
    // No write while reset is held across an edge
    ALU_s0 = ALU_NOT; RF_W_addr = 4'd1; RF_W_en = 1'b1;
    tick();
    idle();
    @(negedge clk);
    reset = 1'b0;
    check_reg("rst_no_write", 4'd1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
